// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - dino runner sequencer: frame tick, obstacle scroll, collision, score; DINO_HISCORE_EN adds hiScore
module dino_game_ctrl #(
  parameter int TICK_DIV  = 750000,
  parameter int DEAD_HOLD = 60,
  parameter int DINO_X    = 20,
  parameter int OBST_W    = 8,
  parameter int OBST_H    = 16,
  parameter int FLOOR_Y   = 101
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       button,
  input  logic [7:0] dinoY,
  output logic       jumpEn,
  output logic       frameTick,
  output logic [7:0] obstX,
  output logic [9:0] score,
  output logic [2:0] speed,
  output logic [1:0] state,
  output logic [9:0] hiScore
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2, BAD = 2'd3} state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(DEAD_HOLD);
  localparam logic [8:0]    HIT_X_MAX = 9'(DINO_X + 7);
  localparam logic [8:0]    HIT_X_MIN = 9'(DINO_X);
  localparam logic [8:0]    OBST_W9   = 9'(OBST_W);
  localparam logic [8:0]    HIT_Y     = 9'(FLOOR_Y + OBST_H);
  localparam logic [9:0]    SCORE_MAX = 10'd999;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_q, hold_d;
  logic          btn_prev, btn_rise, collide;
  logic [7:0]    obst_q, obst_d;
  logic [9:0]    score_q, score_d, score_inc;
  logic [2:0]    speed_q, speed_d;
  logic [8:0]    obst_x9;

  assign frameTick = (tick_cnt == TICK_LAST);
  assign btn_rise  = button & ~btn_prev;
  // 9-bit compare so obstX+OBST_W near 255 cannot wrap into the hit window
  assign obst_x9   = {1'b0, obst_q};
  assign collide   = (state_q == RUN) && (obst_x9 <= HIT_X_MAX) &&
                     ((obst_x9 + OBST_W9) > HIT_X_MIN) && ({1'b0, dinoY} < HIT_Y);
  assign score_inc = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + 10'd1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tick_cnt <= '0;
      btn_prev <= 1'b0;
      state_q  <= IDLE;
      obst_q   <= 8'd255;
      score_q  <= '0;
      speed_q  <= 3'd1;
      hold_q   <= '0;
      jumpEn   <= 1'b0;
    end else begin
      tick_cnt <= frameTick ? '0 : tick_cnt + TW'(1);
      btn_prev <= button;
      state_q  <= state_d;
      obst_q   <= obst_d;
      score_q  <= score_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      jumpEn   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    obst_d  = obst_q;
    score_d = score_q;
    speed_d = speed_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        obst_d = 8'd255;
        if (btn_rise) begin
          state_d = RUN;
          score_d = '0;
          speed_d = 3'd1;
        end
      end
      RUN: begin
        if (collide) begin
          state_d = DEAD;
          hold_d  = '0;
        end else if (frameTick) begin
          if (obst_q < {5'd0, speed_q}) begin
            obst_d  = 8'd255;
            score_d = score_inc;
            if ((score_inc != 10'd0) && (score_inc[3:0] == 4'd0) && (speed_q < 3'd4))
              speed_d = speed_q + 3'd1;
          end else begin
            obst_d = obst_q - {5'd0, speed_q};
          end
        end
      end
      DEAD: begin
        if (frameTick && (hold_q != HOLD_MAX))
          hold_d = hold_q + HW'(1);
        // presses before the hold expires are dropped, not remembered
        if ((hold_q == HOLD_MAX) && btn_rise) begin
          state_d = RUN;
          obst_d  = 8'd255;
          score_d = '0;
          speed_d = 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign obstX = obst_q;
  assign score = score_q;
  assign speed = speed_q;
  assign state = state_q;

`ifdef DINO_HISCORE_EN
  logic [9:0] hi_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      hi_q <= '0;
    else if (collide && (score_q > hi_q))
      hi_q <= score_q;
  end

  assign hiScore = hi_q;
`else
  assign hiScore = '0;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - self-checking bench for dino_game_ctrl
module tb_dino_game_ctrl;

`ifdef DINO_HISCORE_EN
  localparam int HI_EN = 1;
`else
  localparam int HI_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       nRst, button;
  logic [7:0] dinoY;
  logic       jumpEn, frameTick;
  logic [7:0] obstX;
  logic [9:0] score, hiScore;
  logic [2:0] speed;
  logic [1:0] state;

  logic       nRst_f, button_f;
  logic [7:0] dinoY_f;
  logic       jumpEn_f, frameTick_f;
  logic [7:0] obstX_f;
  logic [9:0] score_f, hiScore_f;
  logic [2:0] speed_f;
  logic [1:0] state_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dino_game_ctrl #(.TICK_DIV(4), .DEAD_HOLD(3)) dut (
    .clk(clk), .nRst(nRst), .button(button), .dinoY(dinoY),
    .jumpEn(jumpEn), .frameTick(frameTick), .obstX(obstX), .score(score),
    .speed(speed), .state(state), .hiScore(hiScore)
  );

  // frame tick every cycle so a full 999-point game fits in the run
  dino_game_ctrl #(.TICK_DIV(1), .DEAD_HOLD(3)) dut_fast (
    .clk(clk), .nRst(nRst_f), .button(button_f), .dinoY(dinoY_f),
    .jumpEn(jumpEn_f), .frameTick(frameTick_f), .obstX(obstX_f), .score(score_f),
    .speed(speed_f), .state(state_f), .hiScore(hiScore_f)
  );

  typedef struct {
    logic       btn;
    logic [7:0] dy;
    logic [1:0] st;
    logic [7:0] ox;
    logic [9:0] sc;
    logic [2:0] sp;
    logic       je;
    logic       ft;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 0;
    for (int c = 0; c < 16 && !seen; c++) begin
      if (frameTick === 1'b1) seen = 1;
      else step();
    end
    if (!seen) timeout({tag, " tick"});
  endtask

  // speed is 1 in every game driven here, so each tick moves the obstacle by one
  task automatic run_until(input int target, input string tag);
    logic [7:0] prev_ox;
    logic       prev_ft;
    bit         hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      prev_ox = obstX;
      prev_ft = frameTick;
      step();
      chk({tag, " state"}, state, 1);
      chk({tag, " obstX"}, obstX, prev_ft ? ((prev_ox == 8'd0) ? 255 : prev_ox - 8'd1) : prev_ox);
      if (obstX == 8'(target)) hit = 1;
    end
    if (!hit) timeout({tag, " reach"});
  endtask

  task automatic hold_and_restart(input string tag);
    for (int t = 0; t < 3; t++) begin
      wait_tick(tag);
      step();
    end
    chk({tag, " still dead"}, state, 2);
    button = 1'b1;
    step();
    button = 1'b0;
    chk({tag, " restart state"}, state, 1);
    chk({tag, " restart score"}, score, 0);
    chk({tag, " restart obstX"}, obstX, 255);
    chk({tag, " restart speed"}, speed, 1);
    chk({tag, " restart jumpEn"}, jumpEn, 1);
  endtask

  initial begin
    vec_t e;
    int   wraps;
    int   exp_sc;
    logic [7:0] pf;

    vecs[0] = '{btn:1'b0, dy:8'd101, st:2'd0, ox:8'd255, sc:10'd0, sp:3'd1, je:1'b0, ft:1'b0};
    vecs[1] = '{btn:1'b1, dy:8'd101, st:2'd1, ox:8'd255, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b0};
    vecs[2] = '{btn:1'b1, dy:8'd101, st:2'd1, ox:8'd255, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b1};
    vecs[3] = '{btn:1'b0, dy:8'd101, st:2'd1, ox:8'd254, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b0};
    vecs[4] = '{btn:1'b1, dy:8'd101, st:2'd1, ox:8'd254, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b0};
    vecs[5] = '{btn:1'b0, dy:8'd101, st:2'd1, ox:8'd254, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b0};
    vecs[6] = '{btn:1'b0, dy:8'd101, st:2'd1, ox:8'd254, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b1};
    vecs[7] = '{btn:1'b0, dy:8'd101, st:2'd1, ox:8'd253, sc:10'd0, sp:3'd1, je:1'b1, ft:1'b0};

    nRst = 1'b0; button = 1'b0; dinoY = 8'd101;
    nRst_f = 1'b0; button_f = 1'b0; dinoY_f = 8'd130;
    step();
    step();
    chk("reset state", state, 0);
    chk("reset obstX", obstX, 255);
    chk("reset score", score, 0);
    chk("reset speed", speed, 1);
    chk("reset jumpEn", jumpEn, 0);
    chk("reset frameTick", frameTick, 0);
    chk("reset hiScore", hiScore, 0);
    nRst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      button = vecs[i].btn;
      dinoY  = vecs[i].dy;
      sb_q.push_back(vecs[i]);
      step();
      e = sb_q.pop_front();
      chk($sformatf("vec%0d state", i), state, e.st);
      chk($sformatf("vec%0d obstX", i), obstX, e.ox);
      chk($sformatf("vec%0d score", i), score, e.sc);
      chk($sformatf("vec%0d speed", i), speed, e.sp);
      chk($sformatf("vec%0d jumpEn", i), jumpEn, e.je);
      chk($sformatf("vec%0d frameTick", i), frameTick, e.ft);
    end
    button = 1'b0;

    // game 1: airborne lap scores one, then a grounded collision at x=27
    dinoY = 8'd130;
    run_until(255, "lap");
    chk("lap score", score, 1);
    chk("lap speed", speed, 1);
    dinoY = 8'd101;
    run_until(27, "approach");
    step();
    chk("hit state", state, 2);
    chk("hit obstX frozen", obstX, 27);
    chk("hit score", score, 1);
    chk("hit jumpEn", jumpEn, 0);
    chk("hit hiScore", hiScore, HI_EN ? 1 : 0);

    // early press after two hold ticks must be dropped
    for (int t = 0; t < 2; t++) begin
      wait_tick("hold");
      step();
    end
    button = 1'b1;
    step();
    chk("early press state", state, 2);
    button = 1'b0;
    step();
    chk("early press after", state, 2);
    wait_tick("hold3");
    step();
    chk("hold done no queue", state, 2);
    step();
    chk("hold done idle", state, 2);
    button = 1'b1;
    step();
    button = 1'b0;
    chk("restart state", state, 1);
    chk("restart score", score, 0);
    chk("restart obstX", obstX, 255);
    chk("restart jumpEn", jumpEn, 1);
    chk("restart hiScore", hiScore, HI_EN ? 1 : 0);

    // game 2: collision arrives on a frameTick cycle, so no scroll that tick
    dinoY = 8'd130;
    run_until(27, "glide");
    wait_tick("coll tick");
    chk("coll tick obstX", obstX, 27);
    dinoY = 8'd101;
    step();
    chk("tick+hit state", state, 2);
    chk("tick+hit obstX", obstX, 27);
    chk("tick+hit hiScore kept", hiScore, HI_EN ? 1 : 0);

    // game 3: asynchronous reset mid-run
    hold_and_restart("g3");
    for (int c = 0; c < 10; c++) step();
    chk("g3 moving", obstX < 8'd255, 1);
    #2;
    nRst = 1'b0;
    #1;
    chk("async state", state, 0);
    chk("async obstX", obstX, 255);
    chk("async score", score, 0);
    chk("async jumpEn", jumpEn, 0);
    chk("async speed", speed, 1);
    chk("async frameTick", frameTick, 0);
    chk("async hiScore", hiScore, 0);
    step();
    nRst = 1'b1;
    step();
    chk("post reset idle", state, 0);

    // long game on the fast instance: speed steps every 16 clears, score saturates
    nRst_f = 1'b1;
    step();
    button_f = 1'b1;
    step();
    button_f = 1'b0;
    chk("fast start", state_f, 1);
    wraps = 0;
    pf = obstX_f;
    for (int c = 0; c < 75000 && wraps < 1003; c++) begin
      step();
      if (obstX_f == 8'd255 && pf != 8'd255) begin
        wraps++;
        exp_sc = (wraps > 999) ? 999 : wraps;
        chk($sformatf("clear%0d score", wraps), score_f, exp_sc);
        chk($sformatf("clear%0d speed", wraps), speed_f, (1 + exp_sc / 16 > 4) ? 4 : 1 + exp_sc / 16);
      end
      pf = obstX_f;
    end
    if (wraps < 1003) timeout("fast clears");
    chk("fast final score", score_f, 999);
    chk("fast final speed", speed_f, 4);
    chk("fast final state", state_f, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
